// File: rtl/sampler_trigger_pkg.sv
// sampler_trigger_pkg: state encodings shared by the trigger/capture sequencer
package sampler_trigger_pkg;
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARMED   = 3'd1;
    localparam logic [STATE_W-1:0] ST_DELAY   = 3'd2;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;
    typedef enum logic [STATE_W-1:0] {
        IDLE    = ST_IDLE,
        ARMED   = ST_ARMED,
        DELAY   = ST_DELAY,
        CAPTURE = ST_CAPTURE,
        DONE    = ST_DONE
    } state_e;
endpackage

// File: rtl/sampler_trigger_match.sv
// trigger_match: latched trigger config with level/edge match detection
module trigger_match #(
    parameter int inputBits = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [inputBits-1:0] mask_in,
    input  logic [inputBits-1:0] value_in,
    input  logic                 edge_in,
    input  logic [inputBits-1:0] sample_in,
    output logic                 trig_hit
);
    logic [inputBits-1:0] mask_q, mask_d, value_q, value_d;
    logic edge_q, edge_d, match_prev_q, match_prev_d, match;
    // match uses the incoming config on load so an already-true level is not seen as an edge
    always_comb begin
        mask_d       = load ? mask_in : mask_q;
        value_d      = load ? value_in : value_q;
        edge_d       = load ? edge_in : edge_q;
        match        = ((sample_in ^ value_d) & mask_d) == '0;
        match_prev_d = match;
        trig_hit     = match & ~(edge_d & match_prev_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q       <= '0;
            value_q      <= '0;
            edge_q       <= 1'b0;
            match_prev_q <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            value_q      <= value_d;
            edge_q       <= edge_d;
            match_prev_q <= match_prev_d;
        end
    end
endmodule

// File: rtl/sampler_trigger.sv
// sampler_trigger: arms on a host pulse, waits for trigger and delay, then gates the sampler
module sampler_trigger
    import sampler_trigger_pkg::*;
#(
    parameter int inputBits   = 32,
    parameter int delayBits   = 16,
    parameter int timeoutBits = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [inputBits-1:0]   trig_mask,
    input  logic [inputBits-1:0]   trig_value,
    input  logic                   trig_edge,
    input  logic [delayBits-1:0]   delay,
    input  logic [timeoutBits-1:0] timeout,
    input  logic [inputBits-1:0]   sample_in,
    input  logic                   w_done,
    output logic                   w_enable,
    output logic [STATE_W-1:0]     state,
    output logic                   busy,
    output logic                   triggered,
    output logic                   forced,
    output logic [timeoutBits-1:0] armed_cycles,
    output logic                   done_pulse
);
    state_e state_q, state_d;
    logic [delayBits-1:0] delay_q, delay_d, delay_cnt_q, delay_cnt_d;
    logic [timeoutBits-1:0] timeout_q, timeout_d, armed_cycles_q, armed_cycles_d;
    logic triggered_q, triggered_d, forced_q, forced_d;
    logic w_enable_q, w_enable_d, done_pulse_q, done_pulse_d;
    logic arm_ok, timed_out, trig_hit;
    assign arm_ok = arm & ~abort & (state_q == IDLE || state_q == DONE);
    trigger_match #(.inputBits(inputBits)) u_match (
        .clk      (clk),
        .reset    (reset),
        .load     (arm_ok),
        .mask_in  (trig_mask),
        .value_in (trig_value),
        .edge_in  (trig_edge),
        .sample_in(sample_in),
        .trig_hit (trig_hit)
    );
    always_comb begin
        state_d        = state_q;
        delay_d        = delay_q;
        timeout_d      = timeout_q;
        delay_cnt_d    = delay_cnt_q;
        armed_cycles_d = armed_cycles_q;
        triggered_d    = triggered_q;
        forced_d       = forced_q;
        done_pulse_d   = 1'b0;
        timed_out      = timeout_q != '0 && ({1'b0, armed_cycles_q} + 1'b1) == {1'b0, timeout_q};
        if (abort) begin
            state_d = IDLE;
        end else if (arm_ok) begin
            delay_d        = delay;
            timeout_d      = timeout;
            armed_cycles_d = '0;
            triggered_d    = 1'b0;
            forced_d       = 1'b0;
            state_d        = ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (trig_hit || timed_out) begin
                        triggered_d = 1'b1;
                        forced_d    = ~trig_hit;
                        delay_cnt_d = delay_q - 1'b1;
                        state_d     = delay_q == '0 ? CAPTURE : DELAY;
                    end else begin
                        armed_cycles_d = &armed_cycles_q ? armed_cycles_q : armed_cycles_q + 1'b1;
                    end
                end
                DELAY: begin
                    state_d     = delay_cnt_q == '0 ? CAPTURE : DELAY;
                    delay_cnt_d = delay_cnt_q - 1'b1;
                end
                CAPTURE: begin
                    state_d      = w_done ? DONE : CAPTURE;
                    done_pulse_d = w_done;
                end
                default: ;
            endcase
        end
        w_enable_d = state_d == CAPTURE || state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            delay_q        <= '0;
            timeout_q      <= '0;
            delay_cnt_q    <= '0;
            armed_cycles_q <= '0;
            triggered_q    <= 1'b0;
            forced_q       <= 1'b0;
            w_enable_q     <= 1'b0;
            done_pulse_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_q        <= delay_d;
            timeout_q      <= timeout_d;
            delay_cnt_q    <= delay_cnt_d;
            armed_cycles_q <= armed_cycles_d;
            triggered_q    <= triggered_d;
            forced_q       <= forced_d;
            w_enable_q     <= w_enable_d;
            done_pulse_q   <= done_pulse_d;
        end
    end
    assign state        = state_q;
    assign busy         = state_q == ARMED || state_q == DELAY || state_q == CAPTURE;
    assign triggered    = triggered_q;
    assign forced       = forced_q;
    assign armed_cycles = armed_cycles_q;
    assign w_enable     = w_enable_q;
    assign done_pulse   = done_pulse_q;
endmodule

// File: tb/tb_sampler_trigger.sv
// tb_sampler_trigger: directed vectors with a queued-expectation scoreboard and a 16-deep sampler stub
module tb_sampler_trigger;
    localparam int IW = 32, DW = 16, TW = 5;
    localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_DELAY = 3'd2, S_CAPTURE = 3'd3, S_DONE = 3'd4;
    logic clk = 1'b0, reset = 1'b1, arm = 1'b0, abort = 1'b0, trig_edge = 1'b0, w_done = 1'b0;
    logic [IW-1:0] trig_mask = '0, trig_value = '0, sample_in = '0;
    logic [DW-1:0] delay = '0;
    logic [TW-1:0] timeout = '0;
    logic w_enable, busy, triggered, forced, done_pulse;
    logic [TW-1:0] armed_cycles;
    logic [2:0] state;
    logic [3:0] stub_addr = '0;
    typedef struct {
        string name;
        logic [2:0] st;
        logic we, trg, frc, dp;
        logic [TW-1:0] ac;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    logic e_busy;
    int n_vec = 0, n_fail = 0;

    always #5 clk = ~clk;

    sampler_trigger #(.inputBits(IW), .delayBits(DW), .timeoutBits(TW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .delay(delay), .timeout(timeout), .sample_in(sample_in), .w_done(w_done),
        .w_enable(w_enable), .state(state), .busy(busy), .triggered(triggered),
        .forced(forced), .armed_cycles(armed_cycles), .done_pulse(done_pulse)
    );

    // sampler stand-in: address clears while disabled, done after 16 writes
    always @(posedge clk)
        if (reset || !w_enable) begin
            stub_addr <= '0;
            w_done    <= 1'b0;
        end else if (!w_done) begin
            stub_addr <= stub_addr + 4'd1;
            if (stub_addr == 4'd15) w_done <= 1'b1;
        end

    always @(negedge clk)
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            e_busy = (e.st == S_ARMED) || (e.st == S_DELAY) || (e.st == S_CAPTURE);
            n_vec++;
            if ({state, w_enable, busy, triggered, forced, done_pulse, armed_cycles} !==
                {e.st, e.we, e_busy, e.trg, e.frc, e.dp, e.ac}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d we=%b busy=%b trg=%b frc=%b dp=%b ac=%0d, expected st=%0d we=%b busy=%b trg=%b frc=%b dp=%b ac=%0d",
                         e.name, state, w_enable, busy, triggered, forced, done_pulse, armed_cycles,
                         e.st, e.we, e_busy, e.trg, e.frc, e.dp, e.ac);
            end
        end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] st, input logic we, input logic trg,
                       input logic frc, input logic dp, input logic [TW-1:0] ac);
        exp_q.push_back('{name, st, we, trg, frc, dp, ac});
    endtask

    task automatic do_arm(input logic [IW-1:0] m, input logic [IW-1:0] v, input logic ed,
                          input logic [DW-1:0] d, input logic [TW-1:0] t);
        trig_mask = m; trig_value = v; trig_edge = ed; delay = d; timeout = t; arm = 1'b1;
        cyc();
        arm = 1'b0;
        trig_mask = '0; trig_value = $urandom; trig_edge = ~ed; delay = 16'd7; timeout = 5'd1;
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        chk("reset_state", S_IDLE, 0, 0, 0, 0, 0);
        // level trigger, delay 0, full capture into DONE
        sample_in = '0;
        do_arm(32'hFF, 32'h5A, 1'b0, 16'd0, 5'd0);
        chk("lvl_armed0", S_ARMED, 0, 0, 0, 0, 0);
        cyc(3);
        sample_in = 32'h5A;
        chk("lvl_armed3", S_ARMED, 0, 0, 0, 0, 3);
        cyc();
        chk("lvl_wen", S_CAPTURE, 1, 1, 0, 0, 3);
        cyc(15);
        chk("lvl_cap", S_CAPTURE, 1, 1, 0, 0, 3);
        cyc(2);
        chk("lvl_done", S_DONE, 1, 1, 0, 1, 3);
        cyc();
        chk("lvl_done_once", S_DONE, 1, 1, 0, 0, 3);
        // edge mode armed from DONE while the match already holds
        sample_in = 32'h33;
        do_arm(32'hFF, 32'h33, 1'b1, 16'd0, 5'd0);
        chk("edge_armed0", S_ARMED, 0, 0, 0, 0, 0);
        cyc(4);
        chk("edge_hold", S_ARMED, 0, 0, 0, 0, 4);
        sample_in = '0;
        cyc(6);
        sample_in = 32'h33;
        chk("edge_c10", S_ARMED, 0, 0, 0, 0, 10);
        cyc();
        chk("edge_trig", S_CAPTURE, 1, 1, 0, 0, 10);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("arm_ign_cap", S_CAPTURE, 1, 1, 0, 0, 10);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_cap", S_IDLE, 0, 1, 0, 0, 10);
        // zero mask triggers at once; delay of 5
        sample_in = '0;
        do_arm('0, 32'h1234, 1'b0, 16'd5, 5'd0);
        chk("mask0_armed0", S_ARMED, 0, 0, 0, 0, 0);
        cyc();
        chk("dly_c1", S_DELAY, 0, 1, 0, 0, 0);
        cyc(4);
        chk("dly_c5", S_DELAY, 0, 1, 0, 0, 0);
        cyc();
        chk("dly_wen", S_CAPTURE, 1, 1, 0, 0, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("reset_cap", S_IDLE, 0, 0, 0, 0, 0);
        // forced trigger by timeout
        do_arm(32'hFF, 32'h5A, 1'b0, 16'd0, 5'd20);
        cyc(19);
        chk("to_c19", S_ARMED, 0, 0, 0, 0, 19);
        cyc();
        chk("to_forced", S_CAPTURE, 1, 1, 1, 0, 19);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_sticky", S_IDLE, 0, 1, 1, 0, 19);
        // arm ignored in ARMED, then match and timeout coincide
        do_arm(32'hFF, 32'h5A, 1'b0, 16'd0, 5'd5);
        cyc(2);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("arm_ign_armed", S_ARMED, 0, 0, 0, 0, 3);
        cyc();
        sample_in = 32'h5A;
        chk("tie_c4", S_ARMED, 0, 0, 0, 0, 4);
        cyc();
        chk("tie_match_wins", S_CAPTURE, 1, 1, 0, 0, 4);
        sample_in = '0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        // abort during DELAY
        do_arm('0, '0, 1'b0, 16'd3, 5'd0);
        cyc();
        chk("dly3_c1", S_DELAY, 0, 1, 0, 0, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_dly", S_IDLE, 0, 1, 0, 0, 0);
        cyc(4);
        chk("abort_dly_stay", S_IDLE, 0, 1, 0, 0, 0);
        // arm and abort together
        trig_mask = '0; delay = '0; timeout = '0;
        arm = 1'b1; abort = 1'b1;
        cyc();
        arm = 1'b0; abort = 1'b0;
        chk("arm_abort", S_IDLE, 0, 1, 0, 0, 0);
        cyc(2);
        chk("arm_abort_stay", S_IDLE, 0, 1, 0, 0, 0);
        // armed_cycles saturation
        sample_in = '0;
        do_arm(32'hFF, 32'h5A, 1'b0, 16'd0, 5'd0);
        cyc(40);
        chk("sat_c40", S_ARMED, 0, 0, 0, 0, 5'd31);
        sample_in = 32'h5A;
        cyc();
        chk("sat_trig", S_CAPTURE, 1, 1, 0, 0, 5'd31);
        cyc(2);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/sampler_trigger.md
# sampler_trigger

Trigger and capture sequencer for one `sampler` instance.
- Runs in the sample clock domain and watches the same bus fed to the sampler's `w_in`.
- Drives the sampler's `w_enable` so that capture starts only after a programmable trigger condition and post-trigger delay.
- Holds the filled buffer until the next arm, and reports status for the host-facing wrapper.

## Interface
Parameters:
- `inputBits`, 32, width of sampled bus
- `delayBits`, 16, width of post-trigger delay
- `timeoutBits`, 24, width of auto-trigger timeout and armed-cycle counter

Ports:
- `clk`  in  1  sample clock; the single clock for this block
- `reset`  in  1  synchronous, active-high reset
- `arm`  in  1  pulse; latches the config and starts a capture sequence
- `abort`  in  1  pulse; returns the block to IDLE
- `trig_mask`  in  inputBits  bits that participate in the match
- `trig_value`  in  inputBits  required value of the masked bits
- `trig_edge`  in  1  0 = level match, 1 = rising edge of match
- `delay`  in  delayBits  cycles from trigger to capture start
- `timeout`  in  timeoutBits  0 = wait forever; else force a trigger after this many ARMED cycles
- `sample_in`  in  inputBits  same bus as the sampler's `w_in`
- `w_done`  in  1  sampler's done flag
- `w_enable`  out  1  to the sampler's `w_enable`
- `state`  out  3  current state encoding
- `busy`  out  1  high in ARMED, DELAY or CAPTURE
- `triggered`  out  1  sticky; set when a trigger occurs, cleared on arm
- `forced`  out  1  sticky; set when the trigger came from timeout, cleared on arm
- `armed_cycles`  out  timeoutBits  number of ARMED cycles before the trigger; saturates at all-ones
- `done_pulse`  out  1  one-cycle pulse on entry to DONE

## Operation
- States and encodings: IDLE = 0, ARMED = 1, DELAY = 2, CAPTURE = 3, DONE = 4.
- Priority: reset > abort > all other events.
- `arm` is accepted only in IDLE or DONE. In every other state it is ignored.
- On an accepted `arm`:
  - latch `trig_mask`, `trig_value`, `trig_edge`, `delay` and `timeout`;
  - clear `triggered`, `forced` and `armed_cycles`;
  - go to ARMED.
- Match rule: match = ((`sample_in` ^ value) & mask) == 0, using the latched mask and value.
- `match_prev` is loaded every cycle. On the arm cycle it is loaded with the current match, so a level that is already true does not produce an edge.
- ARMED:
  - the trigger is match in level mode, or match & !`match_prev` in edge mode;
  - `armed_cycles` increments each cycle without a trigger;
  - if timeout ≠ 0 and `armed_cycles` + 1 == timeout with no match, take a forced trigger and set `forced`;
  - if a real match and the timeout occur in the same cycle, the match wins and `forced` stays 0;
  - on any trigger, set `triggered`; go to DELAY if delay ≠ 0, else go to CAPTURE.
- DELAY: the counter is loaded with delay − 1 on entry and counts down. Go to CAPTURE when it reaches 0, which gives exactly `delay` DELAY cycles.
- CAPTURE: when `w_done` = 1, go to DONE and pulse `done_pulse`.
- DONE: keep `w_enable` high so that the sampler's done flag and memory stay valid for readout.
- abort: go to IDLE from any state. Sticky flags are retained.
- `w_enable` is a registered output: 1 in CAPTURE and DONE, 0 in all other states. It is always low for at least one cycle before CAPTURE, which guarantees the sampler's address has been reset to 0.

## Timing
- Reset values: state = IDLE; `w_enable`, `busy`, `triggered`, `forced`, `done_pulse` = 0; `armed_cycles` = 0.
- `arm` in cycle t → `state` = ARMED in cycle t+1.
- Trigger in cycle t with delay = 0 → `w_enable` = 1 in cycle t+1. Sampler memory[0] holds `sample_in` from cycle t+1.
- Trigger with delay = D → `w_enable` rises in cycle t+1+D.
- `w_done` seen in cycle t → `state` = DONE and `done_pulse` = 1 in cycle t+1.
- A mask of all zeros in level mode triggers in the first ARMED cycle (`armed_cycles` = 0).
- `armed_cycles` saturates at all-ones and does not wrap.

## Structure
- Package `sampler_trigger_pkg` holds the state encodings (localparams) and the `STATE_W` = 3 constant.
- Sub-module `trigger_match` contains:
  - the latched mask/value/edge registers;
  - `match_prev`;
  - the `trig_hit` output.
- The state machine and counters stay in `sampler_trigger`.

## Test plan
- Level trigger:
  - stimulus: mask = 0xFF, value = 0x5A, delay = 0; `sample_in` = 0x5A from ARMED cycle 3;
  - required: `armed_cycles` = 3, `w_enable` rises 1 cycle later; with `timeBits` = 4 stub, DONE after 16 cycles and a single `done_pulse`.
- Edge mode:
  - stimulus: `sample_in` already equal to value at arm; it drops, then returns at cycle 10;
  - required: no trigger until cycle 10, `triggered` = 1, `forced` = 0.
- Delay:
  - stimulus: delay = 5;
  - required: exactly 5 DELAY cycles, then `w_enable` = 1.
- Timeout:
  - stimulus: timeout = 20, no match;
  - required: forced trigger, `forced` = 1, `armed_cycles` = 19.
  - stimulus: match and timeout in the same cycle;
  - required: `forced` = 0.
- Abort and reset:
  - stimulus: abort asserted in DELAY; separately, arm and abort in the same cycle;
  - required: IDLE with `w_enable` = 0 in both cases.
  - stimulus: `reset` asserted in CAPTURE;
  - required: all outputs return to their reset values on the next cycle.
- Arm ignored:
  - stimulus: arm pulses while in ARMED or CAPTURE;
  - required: state and latched config unchanged.
  - stimulus: arm in DONE;
  - required: new sequence starts and `w_enable` drops for ≥1 cycle.
